tile_dim_router_fifo: RTL
=========================

Name: tile_dim_router_fifo

Overview:
- One-dimension (X or Y) hop stage of the tile mesh interconnect. Generalised successor of the fixed two-queue cluster FIFO.
- Per-direction transit FIFOs and a local eject FIFO, all with parametrised data width, depth and coordinate width.
- Valid/ready handshakes on every port; anti-starvation arbitration for local inject against transit traffic.
- Instanced once per dimension per tile, chained port-to-port along the row or column.

Parameters:
- DATA_W, 592, flit payload width in bits.
- POS_W, 2, coordinate width in this dimension.
- TILE_POS, 0, this tile's coordinate in this dimension.
- DEPTH, 8, entries per FIFO; power of two, minimum 2.
- STARVE_MAX, 4, consecutive lost arbitrations before local inject is forced to win.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- inj_valid  in  1  local inject request.
- inj_ready  out  1  local inject accepted when valid&ready.
- inj_data  in  DATA_W  inject payload.
- inj_dst  in  POS_W  destination coordinate.
- lnk_in_valid  in  2  link input valid; [0] from lower-coordinate neighbour, [1] from higher.
- lnk_in_ready  out  2  link input ready.
- lnk_in_data  in  2xDATA_W  link input payload.
- lnk_in_dst  in  2xPOS_W  link input destination.
- lnk_out_valid  out  2  link output valid; [0] toward lower coordinates, [1] toward higher.
- lnk_out_ready  in  2  downstream ready.
- lnk_out_data  out  2xDATA_W  link output payload.
- lnk_out_dst  out  2xPOS_W  link output destination.
- ej_valid  out  1  eject flit available.
- ej_ready  in  1  consumer ready.
- ej_data  out  DATA_W  eject payload.
- ej_src  out  2  origin of the eject flit: 0 = link 0, 1 = link 1, 2 = local loopback.
- fifo_level  out  3x$clog2(DEPTH+1)  occupancy of out0, out1 and eject FIFOs.

Behaviour:
- Routing, applied to link inputs and inject alike:
  - dst > TILE_POS goes to the out1 FIFO.
  - dst < TILE_POS goes to the out0 FIFO.
  - dst == TILE_POS goes to the eject FIFO.
  - Comparisons are unsigned, POS_W wide.
- A flit arriving on link p with dst on the wrong side is still routed by the rule above; no drop, no error.
- Each FIFO accepts at most one write per cycle.
- Transit FIFO d has two candidate writers: the opposite link input and inject.
  - Transit wins by default.
  - A per-FIFO starve counter increments on each cycle inject is valid, targets d, and loses.
  - When the counter reaches STARVE_MAX, inject wins and the counter clears. It also clears on any inject win.
- Eject FIFO arbitration: round-robin among link0, link1 and loopback.
  - Pointer advances to one past the granted source after each write.
  - Pointer resets to link0.
- Ready outputs are combinational:
  - A source's ready is high only if it is granted and its target FIFO is not full.
  - Ready must not depend on its own valid for a different target.
- Transfer occurs when valid&ready. A flit written in cycle N is visible at the FIFO head, with out/ej valid, in cycle N+1.
- Output valid equals FIFO non-empty. Data and dst are taken from the head entry.
- Pop on valid&ready.
- Full FIFO:
  - Writers see ready=0.
  - A simultaneous pop does not free the slot in the same cycle, so no write-through on full.
- Empty FIFO: a simultaneous push and pop is legal only via the optional bypass.
- Pointers are $clog2(DEPTH) wide and wrap naturally. The level counter tracks push-pop, range 0..DEPTH.
- Reset is asynchronous and may occur mid-transfer. All FIFOs empty, every valid and ready output 0, fifo_level 0, starve counters 0, RR pointer 0.
- Payload storage is not reset.
- On release, no flit is lost or duplicated other than those discarded by reset.

Optional Feature:
- Macro TILE_FIFO_BYPASS_EN.
- Defined: when a FIFO is empty and its consumer is ready, the granted writer's flit is presented combinationally the same cycle and not stored, giving zero latency. Level stays 0.
- Undefined: always one-cycle minimum latency as above.

Test Plan (TILE_POS=2, POS_W=2, DEPTH=4, STARVE_MAX=4):
- Inject dst=3, data=0xA5 -> lnk_out_valid[1]=1 next cycle with data 0xA5; inject dst=0 -> appears on lnk_out[0]; inject dst=2 -> ej_valid=1, ej_src=2.
- Hold lnk_out_ready[1]=0 and push 5 flits dst=3 from link0 -> first 4 accepted, lnk_in_ready[0]=0 on the 5th, fifo_level[out1]=4. Release ready -> flits drain in order, one per cycle.
- link0 continuously valid with dst=3 while inject is valid with dst=3 -> inject is granted on the 5th contending cycle, then transit resumes.
- link0, link1 and inject all valid with dst=2, ej_ready=1 -> ej_src sequence 0,1,2,0,1,2.
- Assert rst_n low mid-burst with 3 entries queued -> all valid 0 and levels 0 immediately. After release, a new inject dst=3 emerges alone.
- With TILE_FIFO_BYPASS_EN: empty FIFO, inject dst=3, lnk_out_ready[1]=1 -> lnk_out_valid[1]=1 in the same cycle.

Source files
------------

// File: rtl/tile_dim_router_fifo.sv
// tile_dim_router_fifo: one-dimension hop stage of the tile mesh.
// Two transit FIFOs (out0 toward lower, out1 toward higher coordinates) and
// one eject FIFO. Link inputs and local inject are routed by destination.
// Optional macro TILE_FIFO_BYPASS_EN: an empty FIFO whose consumer is ready
// passes the granted writer's flit straight through in the same cycle.

module tile_dim_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [W-1:0]                 wr_data,
  input  logic                         rd_ready,
  output logic                         rd_valid,
  output logic [W-1:0]                 rd_data,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          empty, store, pop;

  assign empty = (cnt_q == '0);
  // A pop in the same cycle never frees a full slot: no write-through.
  assign full  = (cnt_q == LW'(DEPTH));
  assign level = cnt_q;

`ifdef TILE_FIFO_BYPASS_EN
  // Empty FIFO shows the incoming flit directly; it is kept only if not taken.
  assign rd_valid = !empty || wr_en;
  assign rd_data  = empty ? wr_data : mem_q[rp_q];
  assign store    = wr_en && !(empty && rd_ready);
`else
  assign rd_valid = !empty;
  assign rd_data  = mem_q[rp_q];
  assign store    = wr_en;
`endif
  assign pop = !empty && rd_ready;

  // Pointer and occupancy update.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (store) wp_d = wp_q + 1'b1;
    if (pop)   rp_d = rp_q + 1'b1;
    if (store && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!store && pop) cnt_d = cnt_q - 1'b1;
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (store) mem_q[wp_q] <= wr_data;
  end
endmodule

module tile_dim_router_fifo #(
  parameter int DATA_W     = 592,
  parameter int POS_W      = 2,
  parameter int TILE_POS   = 0,
  parameter int DEPTH      = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               inj_valid,
  output logic                               inj_ready,
  input  logic [DATA_W-1:0]                  inj_data,
  input  logic [POS_W-1:0]                   inj_dst,
  input  logic [1:0]                         lnk_in_valid,
  output logic [1:0]                         lnk_in_ready,
  input  logic [1:0][DATA_W-1:0]             lnk_in_data,
  input  logic [1:0][POS_W-1:0]              lnk_in_dst,
  output logic [1:0]                         lnk_out_valid,
  input  logic [1:0]                         lnk_out_ready,
  output logic [1:0][DATA_W-1:0]             lnk_out_data,
  output logic [1:0][POS_W-1:0]              lnk_out_dst,
  output logic                               ej_valid,
  input  logic                               ej_ready,
  output logic [DATA_W-1:0]                  ej_data,
  output logic [1:0]                         ej_src,
  output logic [2:0][$clog2(DEPTH+1)-1:0]    fifo_level
);
  localparam int SW = $clog2(STARVE_MAX+1);
  localparam int TW = POS_W + DATA_W;
  localparam int EW = 2 + DATA_W;
  localparam logic [POS_W-1:0] TP = POS_W'(TILE_POS);

  // Target encoding: 0 = out0, 1 = out1, 2 = eject.
  function automatic logic [1:0] route(input logic [POS_W-1:0] dst);
    if (dst > TP)      return 2'd1;
    else if (dst < TP) return 2'd0;
    else               return 2'd2;
  endfunction

  logic [1:0][1:0]       lnk_tgt;
  logic [1:0]            inj_tgt;
  logic [1:0][2:0]       lnk_req;
  logic [2:0]            inj_req;
  logic [2:0]            ej_req, ej_gnt;
  logic [1:0]            force_inj, lnk_gnt, lnk_fire;
  logic                  inj_gnt, inj_fire;
  logic [3:0]            full;
  logic [2:0]            wr_en;
  logic [1:0][TW-1:0]    tr_wdata, tr_rdata;
  logic [EW-1:0]         ej_wdata, ej_rdata;
  logic [1:0]            ej_wsrc;
  logic [1:0][SW-1:0]    starve_q, starve_d;
  logic [1:0]            rr_q, rr_d;
  logic                  en_q;

  // Route decode and per-target requests.
  always_comb begin
    inj_tgt = route(inj_dst);
    lnk_tgt = '0;
    lnk_req = '0;
    inj_req = '0;
    for (int p = 0; p < 2; p++) lnk_tgt[p] = route(lnk_in_dst[p]);
    for (int t = 0; t < 3; t++) begin
      inj_req[t] = inj_valid && (inj_tgt == 2'(t));
      for (int p = 0; p < 2; p++) lnk_req[p][t] = lnk_in_valid[p] && (lnk_tgt[p] == 2'(t));
    end
    ej_req = {inj_req[2], lnk_req[1][2], lnk_req[0][2]};
  end

  // Eject round-robin: a source wins if nobody between the pointer and it requests.
  always_comb begin
    ej_gnt = '1;
    for (int s = 0; s < 3; s++) begin
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (((int'(rr_q) + k) % 3) == s) seen = 1'b1;
        else if (!seen && ej_req[(int'(rr_q) + k) % 3]) ej_gnt[s] = 1'b0;
      end
    end
  end

  // Transit grants: opposite link, then same-side link, then inject unless starved.
  always_comb begin
    force_inj = '0;
    lnk_gnt   = '0;
    for (int d = 0; d < 2; d++)
      force_inj[d] = inj_req[d] && (starve_q[d] >= SW'(STARVE_MAX));
    for (int p = 0; p < 2; p++) begin
      if (lnk_tgt[p] == 2'd2) lnk_gnt[p] = ej_gnt[p];
      else if (int'(lnk_tgt[p][0]) != p) lnk_gnt[p] = !force_inj[lnk_tgt[p][0]];
      else lnk_gnt[p] = !force_inj[lnk_tgt[p][0]] && !lnk_req[1-p][lnk_tgt[p][0]];
    end
    if (inj_tgt == 2'd2) inj_gnt = ej_gnt[2];
    else inj_gnt = force_inj[inj_tgt[0]] ||
                   !(lnk_req[0][inj_tgt[0]] || lnk_req[1][inj_tgt[0]]);
  end

  assign full[3] = 1'b1;
  always_comb begin
    for (int p = 0; p < 2; p++)
      lnk_in_ready[p] = en_q && lnk_gnt[p] && !full[lnk_tgt[p]];
    inj_ready = en_q && inj_gnt && !full[inj_tgt];
  end
  assign lnk_fire = lnk_in_valid & lnk_in_ready;
  assign inj_fire = inj_valid && inj_ready;

  // Write-data steering; grants are exclusive so at most one source fires per FIFO.
  always_comb begin
    wr_en    = '0;
    tr_wdata = '0;
    ej_wdata = '0;
    ej_wsrc  = 2'd0;
    for (int d = 0; d < 2; d++) begin
      if (lnk_fire[1-d] && lnk_tgt[1-d] == 2'(d)) begin
        wr_en[d] = 1'b1; tr_wdata[d] = {lnk_in_dst[1-d], lnk_in_data[1-d]};
      end else if (lnk_fire[d] && lnk_tgt[d] == 2'(d)) begin
        wr_en[d] = 1'b1; tr_wdata[d] = {lnk_in_dst[d], lnk_in_data[d]};
      end else if (inj_fire && inj_tgt == 2'(d)) begin
        wr_en[d] = 1'b1; tr_wdata[d] = {inj_dst, inj_data};
      end
    end
    if (lnk_fire[0] && lnk_tgt[0] == 2'd2) begin
      wr_en[2] = 1'b1; ej_wsrc = 2'd0; ej_wdata = {2'd0, lnk_in_data[0]};
    end else if (lnk_fire[1] && lnk_tgt[1] == 2'd2) begin
      wr_en[2] = 1'b1; ej_wsrc = 2'd1; ej_wdata = {2'd1, lnk_in_data[1]};
    end else if (inj_fire && inj_tgt == 2'd2) begin
      wr_en[2] = 1'b1; ej_wsrc = 2'd2; ej_wdata = {2'd2, inj_data};
    end
  end

  // Starve counters count inject losses to a writable FIFO; RR pointer follows the winner.
  always_comb begin
    starve_d = starve_q;
    rr_d     = rr_q;
    for (int d = 0; d < 2; d++) begin
      if (inj_fire && inj_tgt == 2'(d)) starve_d[d] = '0;
      else if (en_q && inj_req[d] && !inj_gnt && !full[d]) starve_d[d] = starve_q[d] + 1'b1;
    end
    if (wr_en[2]) rr_d = (ej_wsrc == 2'd2) ? 2'd0 : ej_wsrc + 2'd1;
  end

  // Arbitration state; en_q holds every ready low until the cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      rr_q     <= 2'd0;
      en_q     <= 1'b0;
    end else begin
      starve_q <= starve_d;
      rr_q     <= rr_d;
      en_q     <= 1'b1;
    end
  end

  for (genvar d = 0; d < 2; d++) begin : g_tr
    tile_dim_fifo #(.W(TW), .DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en[d]),
      .wr_data  (tr_wdata[d]),
      .rd_ready (lnk_out_ready[d]),
      .rd_valid (lnk_out_valid[d]),
      .rd_data  (tr_rdata[d]),
      .full     (full[d]),
      .level    (fifo_level[d])
    );
    assign lnk_out_data[d] = tr_rdata[d][DATA_W-1:0];
    assign lnk_out_dst[d]  = tr_rdata[d][TW-1:DATA_W];
  end

  tile_dim_fifo #(.W(EW), .DEPTH(DEPTH)) u_ej (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en[2]),
    .wr_data  (ej_wdata),
    .rd_ready (ej_ready),
    .rd_valid (ej_valid),
    .rd_data  (ej_rdata),
    .full     (full[2]),
    .level    (fifo_level[2])
  );
  assign ej_data = ej_rdata[DATA_W-1:0];
  assign ej_src  = ej_rdata[EW-1:DATA_W];
endmodule
